// File: rtl/counter_pkg.sv
// Shared definitions for the toggle-flip-flop counter: direction encodings
// and the terminal-value helper used by the counter top level.
package counter_pkg;

  localparam logic UP_DIR   = 1'b1;
  localparam logic DOWN_DIR = 1'b0;

  // Terminal value of a modulo-N sequence; callers size-cast to their width.
  function automatic logic [31:0] max_count(input int unsigned modulus);
    return 32'(modulus - 32'd1);
  endfunction

endpackage

// File: rtl/counter_tff_mod_tff_cell.sv
// Single toggle flip-flop cell: Q inverts on every rising edge where T is high,
// and is cleared asynchronously by an active-high reset.
module tff_cell (
  input  logic CLK,
  input  logic RST,
  input  logic T,
  output logic Q,
  output logic QBAR
);

  logic q_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= 1'b0;
    end else if (T) begin
      q_q <= ~q_q;
    end
  end

  assign Q    = q_q;
  assign QBAR = ~q_q;

endmodule

// File: rtl/counter_tff_mod.sv
// Parametrised up/down modulo counter with parallel load, built from WIDTH
// toggle cells. TC feeds the enable of a cascaded stage; WRAP/ERR are pulses.
module counter_tff_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             TC,
  output logic             WRAP,
  output logic             ERR
);

  // One extra bit so that MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULUS));

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qbar_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_vec;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             at_max;
  logic             at_zero;
  logic             d_legal;

  assign at_max  = (q_q == MAX_Q);
  assign at_zero = (q_q == '0);
  assign d_legal = ({1'b0, D} < MOD_W);

  // Next-state: LOAD has priority over EN; otherwise hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (LOAD) begin
      if (d_legal) begin
        q_d = D;
      end else begin
        q_d   = '0;
        err_d = 1'b1;
      end
    end else if (EN) begin
      if (UP == UP_DIR) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_Q;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // A cell toggles exactly where the current and next count differ.
  assign t_vec = q_q ^ q_d;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .CLK  (CLK),
        .RST  (RST),
        .T    (t_vec[gi]),
        .Q    (q_q[gi]),
        .QBAR (qbar_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign TC   = EN & ~LOAD & (((UP == UP_DIR) & at_max) | ((UP == DOWN_DIR) & at_zero));
  assign Q    = q_q;
  assign QBAR = qbar_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_counter_tff_mod.sv
// Randomised and directed bench for counter_tff_mod: modulo-16 and modulo-10
// instances share one stimulus bus; a two-digit decade cascade is checked too.
module tb_counter_tff_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] d = 4'd0;
  logic       cen = 1'b0;

  logic [3:0] q16, qb16, q10, qb10, cq0, cqb0, cq1, cqb1;
  logic       tc16, wr16, er16, tc10, wr10, er10;
  logic       ctc0, cwr0, cer0, ctc1, cwr1, cer1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference state
  int  m16_q = 0, m10_q = 0;
  bit  m16_w = 0, m16_e = 0, m10_w = 0, m10_e = 0;

  always #5 clk = ~clk;

  counter_tff_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q16), .QBAR(qb16), .TC(tc16), .WRAP(wr16), .ERR(er16));

  counter_tff_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q10), .QBAR(qb10), .TC(tc10), .WRAP(wr10), .ERR(er10));

  counter_tff_mod #(.WIDTH(4), .MODULUS(10)) cas0 (
    .CLK(clk), .RST(rst), .EN(cen), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(cq0), .QBAR(cqb0), .TC(ctc0), .WRAP(cwr0), .ERR(cer0));

  counter_tff_mod #(.WIDTH(4), .MODULUS(10)) cas1 (
    .CLK(clk), .RST(rst), .EN(ctc0), .UP(1'b1), .LOAD(1'b0), .D(4'd0),
    .Q(cq1), .QBAR(cqb1), .TC(ctc1), .WRAP(cwr1), .ERR(cer1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Spec-level model: modular arithmetic on an integer count.
  task automatic mdl(input int m, inout int q, output bit w, output bit e);
    w = 0;
    e = 0;
    if (load) begin
      if (int'(d) < m) q = int'(d);
      else begin q = 0; e = 1; end
    end else if (en) begin
      if (up) begin w = (q == m - 1); q = (q + 1) % m; end
      else    begin w = (q == 0);     q = (q + m - 1) % m; end
    end
  endtask

  function automatic bit mdl_tc(input int m, input int q);
    return en & ~load & ((up & (q == m - 1)) | (~up & (q == 0)));
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".q16"},  32'(q16),  32'(m16_q));
    chk({tag, ".qb16"}, 32'(qb16), 32'(~m16_q & 15));
    chk({tag, ".w16"},  32'(wr16), 32'(m16_w));
    chk({tag, ".e16"},  32'(er16), 32'(m16_e));
    chk({tag, ".q10"},  32'(q10),  32'(m10_q));
    chk({tag, ".qb10"}, 32'(qb10), 32'(~m10_q & 15));
    chk({tag, ".w10"},  32'(wr10), 32'(m10_w));
    chk({tag, ".e10"},  32'(er10), 32'(m10_e));
  endtask

  // One transaction: inputs already set; check TC, clock, check state.
  task automatic step(input string tag);
    #1;
    chk({tag, ".tc16"}, 32'(tc16), 32'(mdl_tc(16, m16_q)));
    chk({tag, ".tc10"}, 32'(tc10), 32'(mdl_tc(10, m10_q)));
    @(posedge clk);
    mdl(16, m16_q, m16_w, m16_e);
    mdl(10, m10_q, m10_w, m10_e);
    #1;
    check_outputs(tag);
    $display("[%0t] %s en=%0b up=%0b ld=%0b d=%0d | m16 q=%0d w=%0b e=%0b | m10 q=%0d w=%0b e=%0b",
             $time, tag, en, up, load, d, q16, wr16, er16, q10, wr10, er10);
  endtask

  // Pulse reset between edges and check that it acts immediately.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m16_q = 0; m16_w = 0; m16_e = 0;
    m10_q = 0; m10_w = 0; m10_e = 0;
    check_outputs(tag);
    $display("[%0t] %s async reset", $time, tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset
    #2;
    check_outputs("rst");
    chk("rst.cq0", 32'(cq0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Up count through both wraps
    en = 1; up = 1; load = 0;
    for (int i = 0; i < 17; i++) step("up");
    chk("up17.q16", 32'(q16), 1);
    chk("up17.q10", 32'(q10), 7);

    // Down wrap from 1
    load = 1; d = 4'd1; step("ld1");
    load = 0; up = 0;
    for (int i = 0; i < 3; i++) step("down");
    chk("down.q10", 32'(q10), 8);
    chk("down.q16", 32'(q16), 14);

    // Load beats enable; illegal load for modulus 10
    en = 1; up = 1; load = 1; d = 4'd7; step("ld7");
    d = 4'd12; step("ld12");
    chk("ld12.err10", 32'(er10), 1);
    chk("ld12.q10", 32'(q10), 0);
    load = 0; en = 0; step("ld12post");
    chk("ld12post.err10", 32'(er10), 0);

    // Hold
    load = 1; d = 4'd9; en = 1; step("ld9");
    load = 0; en = 0;
    for (int i = 0; i < 5; i++) step("hold");

    // Wrap then asynchronous reset mid-cycle
    en = 1; up = 1; step("wrap9");
    load = 1; d = 4'd6; step("ld6");
    load = 0; en = 0;
    async_reset("arst");

    // Randomised stimulus
    for (int i = 0; i < 400; i++) begin
      en   = 1'($urandom_range(0, 3) != 0);
      up   = 1'($urandom);
      load = 1'($urandom_range(0, 9) == 0);
      d    = 4'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      step("rnd");
      chk("rnd.range10", 32'(q10 < 4'd10), 1);
    end

    // Two-digit decade cascade
    en = 0; load = 0;
    async_reset("cas_rst");
    chk("cas_rst.cq1", 32'(cq1), 0);
    cen = 1;
    for (int k = 1; k <= 100; k++) begin
      #1;
      chk("cas.tc0", 32'(ctc0), 32'((k - 1) % 10 == 9));
      @(posedge clk);
      #1;
      chk("cas.ones", 32'(cq0), 32'(k % 10));
      chk("cas.tens", 32'(cq1), 32'((k / 10) % 10));
      chk("cas.qb1", 32'(cqb1), 32'(~((k / 10) % 10) & 15));
      chk("cas.wr1", 32'(cwr1), 32'(k == 100));
      chk("cas.err", 32'({cer0, cer1}), 0);
      chk("cas.qb0", 32'(cqb0), 32'(~(k % 10) & 15));
      $display("[%0t] cascade k=%0d tens=%0d ones=%0d tc1=%0b", $time, k, cq1, cq0, ctc1);
    end
    cen = 0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
